// File: rtl/fir_requant_fifo.sv
// FIR output stage: decimate, requantize 2N -> N bits (round half up, saturate), buffer in a FIFO.
// Optional saturation counter enabled by defining FIR_RQ_SATCNT_EN.
module fir_requant_fifo #(
    parameter int unsigned N     = 16,
    parameter int unsigned SHW   = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [2*N-1:0]         y_in,
    input  logic [SHW-1:0]         shift,
    input  logic [DW-1:0]          decim,
    input  logic                   clr,
    output logic [N-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sat,
    output logic                   ovf
`ifdef FIR_RQ_SATCNT_EN
    ,
    output logic [15:0]            sat_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic signed [2*N:0] ONE = (2*N+1)'(1);
    localparam logic signed [2*N:0] SAT_HI = (2*N+1)'((1 << (N-1)) - 1);
    localparam logic signed [2*N:0] SAT_LO = ~SAT_HI;

    // Decimation phase
    logic [DW-1:0] cnt_q;
    logic          kept;

    assign kept = ena && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= (cnt_q >= decim) ? '0 : cnt_q + 1'b1;
        end
    end

    // Stage 1: round and shift in 2N+1 bits so the rounding add cannot wrap
    logic signed [2*N:0] rnd, sum, r_d, r_q;
    logic                v1_q;

    always_comb begin
        rnd = (shift == '0) ? '0 : (ONE << (shift - 1'b1));
        sum = $signed({y_in[2*N-1], y_in}) + rnd;
        r_d = sum >>> shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            r_q  <= '0;
        end else begin
            v1_q <= kept;
            if (kept) begin
                r_q <= r_d;
            end
        end
    end

    // Stage 2: saturate; the result is the FIFO write-port register
    logic [N-1:0] w_d, w_q;
    logic         v2_q;
    logic         sat_hit;

    always_comb begin
        w_d = r_q[N-1:0];
        if (r_q > SAT_HI) begin
            w_d = {1'b0, {(N-1){1'b1}}};
        end else if (r_q < SAT_LO) begin
            w_d = {1'b1, {(N-1){1'b0}}};
        end
    end

    assign sat_hit = v1_q && ((r_q > SAT_HI) || (r_q < SAT_LO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q <= 1'b0;
            w_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                w_q <= w_d;
            end
        end
    end

    // FIFO
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]   level_q;
    logic [N-1:0]  head_d, head_q;
    logic          rd, wr, full, drop;

    assign out_valid = (level_q != '0);
    assign full      = (level_q == FULL_LVL);
    assign rd        = out_valid && out_ready;
    assign wr        = v2_q && (!full || rd);
    assign drop      = v2_q && full && !rd;
    assign rd_nxt    = rd_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= w_q;
        end
    end

    // Registered head: follows the entry that will be at rd_ptr after this edge
    always_comb begin
        head_d = head_q;
        if (level_q == '0) begin
            if (wr) head_d = w_q;
        end else if (rd) begin
            if (level_q == (AW+1)'(1)) begin
                if (wr) head_d = w_q;
            end else begin
                head_d = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            head_q <= head_d;
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_nxt;
            if (wr && !rd) begin
                level_q <= level_q + 1'b1;
            end else if (rd && !wr) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign out_data = head_q;
    assign level    = level_q;

    // Sticky flags: a new event in the clear cycle wins
    logic sat_q, ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sat_q <= (sat_q && !clr) || sat_hit;
            ovf_q <= (ovf_q && !clr) || drop;
        end
    end

    assign sat = sat_q;
    assign ovf = ovf_q;

`ifdef FIR_RQ_SATCNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else if (clr) begin
            sat_cnt_q <= {15'd0, sat_hit};
        end else if (sat_hit && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_requant_fifo.sv
// Bench for fir_requant_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_fir_requant_fifo;

    localparam int N = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [31:0] y_in;
    logic [4:0]  shift;
    logic [7:0]  decim;
    logic        clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        sat;
    logic        ovf;
`ifdef FIR_RQ_SATCNT_EN
    logic [15:0] sat_cnt;
`endif

    fir_requant_fifo #(.N(16), .SHW(5), .DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .y_in      (y_in),
        .shift     (shift),
        .decim     (decim),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .sat       (sat),
        .ovf       (ovf)
`ifdef FIR_RQ_SATCNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: integer arithmetic, a two-deep delay line and a queue
    int          m_cnt;
    bit          p1v, p2v;
    longint      p1r;
    logic [15:0] p2w;
    logic [15:0] q[$];
    logic [15:0] m_last;
    bit          m_sat, m_ovf;
    int          m_satcnt;

    function automatic longint requant(logic [31:0] y, int sh);
        longint v;
        v = longint'($signed(y));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        return v >>> sh;
    endfunction

    task automatic model_reset();
        m_cnt = 0; p1v = 0; p2v = 0; p1r = 0; p2w = 0;
        q.delete();
        m_last = 16'h0000; m_sat = 0; m_ovf = 0; m_satcnt = 0;
    endtask

    task automatic model_edge();
        bit rdq;
        bit sat_now;
        rdq = (q.size() != 0) && out_ready;
        sat_now = 0;
        if (clr) begin
            m_sat = 0; m_ovf = 0; m_satcnt = 0;
        end
        if (rdq) void'(q.pop_front());
        if (p2v) begin
            if (q.size() < DEPTH) q.push_back(p2w);
            else m_ovf = 1;
        end
        p2v = p1v;
        if (p1v) begin
            if (p1r > 32767) begin
                p2w = 16'h7FFF; sat_now = 1;
            end else if (p1r < -32768) begin
                p2w = 16'h8000; sat_now = 1;
            end else begin
                p2w = p1r[15:0];
            end
        end
        if (sat_now) begin
            m_sat = 1;
            if (m_satcnt < 65535) m_satcnt++;
        end
        p1v = 0;
        if (ena) begin
            if (m_cnt == 0) begin
                p1v = 1;
                p1r = requant(y_in, int'(shift));
            end
            m_cnt = (m_cnt >= int'(decim)) ? 0 : m_cnt + 1;
        end
        if (q.size() != 0) m_last = q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level);
        else n_pass++;
        n_total++;
        if (out_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", out_data);
        else n_pass++;
        n_total++;
        if (sat !== 1'b0 || ovf !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", sat, ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        decim = 8'd0; shift = 5'd0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena = 1'b1; y_in = 32'(i + 5);
            tick();
        end
        ena = 1'b0;
        tick();
        n_total++;
        if (level !== 3'(q.size()) || level !== 3'd2)
            $display("FAIL mid_fill_level: got %0d want %0d", level, q.size());
        else n_pass++;
        rst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || level !== 3'd0)
            $display("FAIL mid_reset_now: got valid=%b level=%0d want 0/0", out_valid, level);
        else n_pass++;
        n_total++;
        if (sat !== 1'b0 || ovf !== 1'b0) $display("FAIL mid_reset_flags: got %b%b want 00", sat, ovf);
        else n_pass++;
        rst = 1'b1;
        repeat (4) tick();
        n_total++;
        if (out_valid !== 1'b0 || level !== 3'd0)
            $display("FAIL mid_reset_stale: got valid=%b level=%0d want 0/0", out_valid, level);
        else n_pass++;
    endtask

    task automatic test_latency();
        decim = 8'd0; shift = 5'd8; out_ready = 1'b0;
        ena = 1'b1; y_in = 32'h0000_1280;
        tick();
        ena = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got valid=%b want 0", out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0013)
            $display("FAIL latency_data: got valid=%b data=%h want 1/0013", out_valid, out_data);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0013)
            $display("FAIL latency_drain: got valid=%b data=%h want 0/0013", out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_round_sat();
        logic [31:0] ys [3];
        logic [4:0]  shs [3];
        logic [15:0] exps [3];
        ys = '{32'hFFFF_FE80, 32'h0001_0000, 32'hFFFF_0000};
        shs = '{5'd8, 5'd0, 5'd0};
        exps = '{16'hFFFF, 16'h7FFF, 16'h8000};
        decim = 8'd0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ena = 1'b1; y_in = ys[i]; shift = shs[i];
            tick();
            ena = 1'b0;
            tick();
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== exps[i])
                $display("FAIL round_sat_%0d: got valid=%b data=%h want 1/%h",
                         i, out_valid, out_data, exps[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (sat !== 1'b0) $display("FAIL round_no_sat: got %b want 0", sat);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (sat !== 1'b1) $display("FAIL sat_sticky: got %b want 1", sat);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++;
        if (sat !== 1'b0) $display("FAIL sat_clear: got %b want 0", sat);
        else n_pass++;
    endtask

    task automatic test_decim();
        logic [15:0] got[$];
        logic [15:0] exp[$];
        logic [15:0] first[3];
        first = '{16'd0, 16'd4, 16'd8};
        decim = 8'd3; shift = 5'd0; out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 14) decim = 8'd0;
            ena = (i < 18);
            y_in = 32'(i);
            if (out_valid && out_ready) got.push_back(out_data);
            if (q.size() != 0 && out_ready) exp.push_back(q[0]);
            tick();
        end
        ena = 1'b0;
        n_total++;
        if (got.size() != exp.size()) $display("FAIL decim_count: got %0d want %0d", got.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (got.size() <= i || got[i] !== first[i])
                $display("FAIL decim_first_%0d: got %h want %h", i, (got.size() > i) ? got[i] : 16'hxxxx, first[i]);
            else n_pass++;
        end
        for (int i = 3; i < exp.size(); i++) begin
            n_total++;
            if (got.size() <= i || got[i] !== exp[i])
                $display("FAIL decim_tail_%0d: got %h want %h", i, (got.size() > i) ? got[i] : 16'hxxxx, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        decim = 8'd0; shift = 5'd0; out_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ena = 1'b1; y_in = 32'(i);
            tick();
        end
        ena = 1'b0;
        tick();
        tick();
        n_total++;
        if (level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level);
        else n_pass++;
        n_total++;
        if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf);
        else n_pass++;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 16'(k))
                $display("FAIL ovf_drain_%0d: got valid=%b data=%h want 1/%h", k, out_valid, out_data, 16'(k));
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 16'd4 || level !== 3'd0)
            $display("FAIL ovf_empty: got valid=%b data=%h level=%0d want 0/0004/0", out_valid, out_data, level);
        else n_pass++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_rw();
        decim = 8'd0; shift = 5'd0; out_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            ena = 1'b1; y_in = 32'(i);
            tick();
        end
        ena = 1'b0;
        tick();
        tick();
        ena = 1'b1; y_in = 32'd15;
        tick();
        ena = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (level !== 3'd4 || ovf !== 1'b0)
            $display("FAIL full_rw: got level=%0d ovf=%b want 4/0", level, ovf);
        else n_pass++;
        out_ready = 1'b1;
        for (int k = 12; k <= 15; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 16'(k))
                $display("FAIL full_rw_order_%0d: got valid=%b data=%h want 1/%h", k, out_valid, out_data, 16'(k));
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL full_rw_empty: got %b want 0", out_valid);
        else n_pass++;
    endtask

`ifdef FIR_RQ_SATCNT_EN
    task automatic test_sat_cnt();
        decim = 8'd0; shift = 5'd0; out_ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena = 1'b1; y_in = (i == 1) ? 32'h8000_0000 : 32'h0010_0000;
            tick();
        end
        ena = 1'b0;
        tick();
        tick();
        n_total++;
        if (sat_cnt !== 16'd3) $display("FAIL sat_cnt_three: got %0d want 3", sat_cnt);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++;
        if (sat_cnt !== 16'd0) $display("FAIL sat_cnt_clear: got %0d want 0", sat_cnt);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        decim = 8'd1;
        for (int c = 0; c < 400; c++) begin
            ena = ($urandom_range(0, 3) != 0);
            y_in = $urandom;
            shift = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 31) == 0) decim = 8'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick();
            n_total++;
            if (out_valid !== (q.size() != 0) || level !== 3'(q.size()))
                $display("FAIL rnd_occ_%0d: got valid=%b level=%0d want level=%0d", c, out_valid, level, q.size());
            else n_pass++;
            n_total++;
            if (out_data !== m_last) $display("FAIL rnd_data_%0d: got %h want %h", c, out_data, m_last);
            else n_pass++;
            n_total++;
            if (sat !== m_sat || ovf !== m_ovf)
                $display("FAIL rnd_flags_%0d: got sat=%b ovf=%b want %b/%b", c, sat, ovf, m_sat, m_ovf);
            else n_pass++;
`ifdef FIR_RQ_SATCNT_EN
            n_total++;
            if (sat_cnt !== 16'(m_satcnt)) $display("FAIL rnd_satcnt_%0d: got %0d want %0d", c, sat_cnt, m_satcnt);
            else n_pass++;
`endif
        end
        clr = 1'b0;
        ena = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; y_in = '0; shift = '0; decim = '0; clr = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset_mid();
        test_latency();
        test_round_sat();
        test_decim();
        test_overflow();
        test_full_rw();
`ifdef FIR_RQ_SATCNT_EN
        test_sat_cnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
